// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: serialises cfg words MSB-first onto ccff_head under a
// gated shift enable and repacks the bits leaving ccff_tail into readback words.
module ccff_bitstream_loader #(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_word,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_word,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WCNT_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [WORD_W-1:0]   sreg_q;
  logic [WORD_W-1:0]   rb_sreg_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [WCNT_W-1:0]   word_cnt_q;
  logic                cfg_ready_q;
  logic                shift_en_q;
  logic                head_q;
  logic [WORD_W-1:0]   rb_word_q;
  logic                rb_valid_q;
  logic                busy_q;
  logic                done_q;

  logic [WORD_W-1:0]   sreg_d;
  logic [WORD_W-1:0]   rb_sreg_d;
  logic [WORD_W-1:0]   rb_aligned_d;
  logic [CNT_W-1:0]    bit_cnt_d;
  logic [WCNT_W-1:0]   word_cnt_d;
  logic                last_bit_c;
  logic                word_end_c;

  // Per-shift datapath: next shift-register values and end-of-word / end-of-chain detection
  assign sreg_d       = sreg_q << 1;
  assign rb_sreg_d    = (rb_sreg_q << 1) | WORD_W'(ccff_tail);
  assign bit_cnt_d    = bit_cnt_q + CNT_W'(1);
  assign word_cnt_d   = word_cnt_q + WCNT_W'(1);
  assign last_bit_c   = (bit_cnt_d == CNT_W'(CHAIN_LEN));
  assign word_end_c   = (word_cnt_d == WCNT_W'(WORD_W));
  // A short final word has word_cnt_d valid bits at the LSBs; push them to the MSB end
  assign rb_aligned_d = rb_sreg_d << (WCNT_W'(WORD_W) - word_cnt_d);

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      rb_sreg_q   <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      cfg_ready_q <= 1'b0;
      shift_en_q  <= 1'b0;
      head_q      <= 1'b0;
      rb_word_q   <= '0;
      rb_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      if (abort) begin
        state_q     <= S_IDLE;
        cfg_ready_q <= 1'b0;
        shift_en_q  <= 1'b0;
        head_q      <= 1'b0;
        busy_q      <= 1'b0;
        done_q      <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start) begin
              state_q     <= S_FETCH;
              bit_cnt_q   <= '0;
              cfg_ready_q <= 1'b1;
              busy_q      <= 1'b1;
              done_q      <= 1'b0;
            end
          end
          S_FETCH: begin
            if (cfg_valid) begin
              state_q     <= S_SHIFT;
              sreg_q      <= cfg_word;
              word_cnt_q  <= '0;
              cfg_ready_q <= 1'b0;
              shift_en_q  <= 1'b1;
              head_q      <= cfg_word[WORD_W-1];
            end
          end
          S_SHIFT: begin
            sreg_q     <= sreg_d;
            rb_sreg_q  <= rb_sreg_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            if (last_bit_c) begin
              state_q    <= S_DONE;
              shift_en_q <= 1'b0;
              head_q     <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              rb_word_q  <= rb_aligned_d;
              rb_valid_q <= 1'b1;
            end else if (word_end_c) begin
              state_q     <= S_FETCH;
              shift_en_q  <= 1'b0;
              head_q      <= 1'b0;
              cfg_ready_q <= 1'b1;
              rb_word_q   <= rb_sreg_d;
              rb_valid_q  <= 1'b1;
            end else begin
              head_q <= sreg_d[WORD_W-1];
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign shift_en  = shift_en_q;
  assign ccff_head = head_q;
  assign rb_word   = rb_word_q;
  assign rb_valid  = rb_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: two instances (20-bit and 16-bit chains) driven
// through a shared stimulus task and checked against a bit-level chain/stream model.
module tb_ccff_bitstream_loader;

  localparam int W  = 8;
  localparam int LA = 20;
  localparam int LB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b0;
  logic         start = 1'b0, abort = 1'b0, cfg_valid = 1'b0;
  logic [W-1:0] cfg_word = '0;
  bit           sel = 1'b0;

  logic         a_ready, a_head, a_shift, a_tail, a_rbv, a_busy, a_done;
  logic [W-1:0] a_rbw;
  logic         b_ready, b_head, b_shift, b_tail, b_rbv, b_busy, b_done;
  logic [W-1:0] b_rbw;

  ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(LA)) dut_a (
    .prog_clk(clk), .pReset(rst), .start(start & ~sel), .abort(abort & ~sel),
    .cfg_word(cfg_word), .cfg_valid(cfg_valid & ~sel), .cfg_ready(a_ready),
    .ccff_head(a_head), .shift_en(a_shift), .ccff_tail(a_tail), .rb_word(a_rbw),
    .rb_valid(a_rbv), .busy(a_busy), .done(a_done)
  );

  ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(LB)) dut_b (
    .prog_clk(clk), .pReset(rst), .start(start & sel), .abort(abort & sel),
    .cfg_word(cfg_word), .cfg_valid(cfg_valid & sel), .cfg_ready(b_ready),
    .ccff_head(b_head), .shift_en(b_shift), .ccff_tail(b_tail), .rb_word(b_rbw),
    .rb_valid(b_rbv), .busy(b_busy), .done(b_done)
  );

  // Behavioural chains: shift head in at bit 0, tail leaves from the top bit
  logic          pre_en = 1'b0;
  logic [31:0]   pre_val = '0;
  logic [LA-1:0] a_chain;
  logic [LB-1:0] b_chain;
  always @(posedge clk) begin
    if (pre_en) begin
      a_chain <= pre_val[LA-1:0];
      b_chain <= pre_val[LB-1:0];
    end else begin
      if (a_shift) a_chain <= {a_chain[LA-2:0], a_head};
      if (b_shift) b_chain <= {b_chain[LB-2:0], b_head};
    end
  end
  assign a_tail = a_chain[LA-1];
  assign b_tail = b_chain[LB-1];

  logic         o_ready, o_head, o_shift, o_rbv, o_busy, o_done;
  logic [W-1:0] o_rbw;
  assign o_ready = sel ? b_ready : a_ready;
  assign o_head  = sel ? b_head  : a_head;
  assign o_shift = sel ? b_shift : a_shift;
  assign o_rbv   = sel ? b_rbv   : a_rbv;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;
  assign o_rbw   = sel ? b_rbw   : a_rbw;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] wds [4];
  bit           heads [$];
  logic [W-1:0] rbs [$];
  int           idle_viol;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  task automatic preload(input logic [31:0] v);
    @(negedge clk);
    pre_val = v;
    pre_en  = 1'b1;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  function automatic logic [31:0] cur_chain();
    return sel ? 32'(b_chain) : 32'(a_chain);
  endfunction

  // One load: optional gap cycles before each word, optional abort/reset at shift index
  // kill_at, and a stray start pulse at loop cycle 'stray' while the loader is busy.
  task automatic run_load(input int nw, input int gap, input int kill_at, input bit kill_rst,
                          input int stray);
    int          L, c, widx, gapc, n, nexp, lim;
    bit          killed;
    logic [31:0] old, ev, gv, ew, mask;
    L    = sel ? LB : LA;
    old  = cur_chain();
    mask = (32'd1 << L) - 32'd1;
    heads.delete();
    rbs.delete();
    idle_viol = 0;
    killed = 1'b0;
    widx = 0;
    gapc = gap;
    ev = '0;
    for (int i = 0; i < L; i++) ev[L-1-i] = wds[i/W][W-1-(i%W)];
    @(negedge clk);
    start = 1'b1;
    for (c = 0; c < 300; c++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; rst = 1'b0;
      if (c == 0) chk("ready_latency", 32'(o_ready), 32'd1);
      if (o_shift) heads.push_back(o_head);
      else if (o_head) idle_viol++;
      if (o_rbv) begin
        rbs.push_back(o_rbw);
        lim = (rbs.size() * W < L) ? rbs.size() * W : L;
        chk("rb_valid_timing", 32'(heads.size()), 32'(lim));
      end
      if (killed || o_done) break;
      if (kill_at >= 0 && o_shift && heads.size() == kill_at + 1) begin
        if (kill_rst) rst = 1'b1;
        else abort = 1'b1;
        killed = 1'b1;
      end else begin
        if (c == stray) start = 1'b1;
        if (o_ready && widx < nw) begin
          if (gapc > 0) gapc--;
          else begin
            cfg_valid = 1'b1;
            cfg_word  = wds[widx];
            widx++;
            gapc = gap;
          end
        end
      end
    end
    if (c >= 300) chk("load_in_budget", 32'd0, 32'd1);
    chk("head_zero_when_idle", 32'(idle_viol), 32'd0);
    if (killed) begin
      n = kill_at + 1;
      chk("kill_outputs", 32'({o_ready, o_shift, o_head, o_rbv, o_busy, o_done}), 32'd0);
      if (kill_rst) chk("reset_rb_word", 32'(o_rbw), 32'd0);
      chk("kill_shift_count", 32'(heads.size()), 32'(n));
      chk("kill_rb_count", 32'(rbs.size()), 32'(kill_at / W));
      chk("kill_chain_partial", cur_chain(), ((old << n) | (ev >> (L - n))) & mask);
    end else begin
      chk("load_cycles", 32'(c), 32'(nw * (1 + gap) + L));
      chk("shift_count", 32'(heads.size()), 32'(L));
      gv = '0;
      for (int i = 0; i < heads.size() && i < L; i++) gv[L-1-i] = heads[i];
      chk("head_stream", gv, ev);
      chk("chain_final", cur_chain(), ev);
      chk("done_status", 32'({o_done, o_busy, o_ready, o_shift}), 32'b1000);
      nexp = (L + W - 1) / W;
      chk("rb_count", 32'(rbs.size()), 32'(nexp));
      for (int k = 0; k < rbs.size() && k < nexp; k++) begin
        ew = '0;
        for (int j = 0; j < W; j++) begin
          n = k * W + (W - 1 - j);
          if (n < L) ew[j] = old[L-1-n];
        end
        chk($sformatf("rb_word%0d", k), 32'(rbs[k]), ew);
      end
    end
  endtask

  task automatic rand_words();
    for (int i = 0; i < 4; i++) wds[i] = W'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_a", 32'({a_ready, a_head, a_shift, a_rbv, a_busy, a_done, a_rbw}), 32'd0);
    chk("reset_b", 32'({b_ready, b_head, b_shift, b_rbv, b_busy, b_done, b_rbw}), 32'd0);
    rst = 1'b0;

    sel = 1'b0;
    wds[0] = 8'hA5; wds[1] = 8'h3C; wds[2] = 8'hF0; wds[3] = 8'h00;
    preload(32'hFFFFF);
    run_load(3, 0, -1, 1'b0, 4);
    chk("directed_chain", cur_chain(), 32'hA53CF);
    if (rbs.size() == 3) chk("directed_rb", {8'h00, rbs[0], rbs[1], rbs[2]}, 32'h00FFFFF0);
    else chk("directed_rb_count", 32'(rbs.size()), 32'd3);

    preload(32'hFFFFF);
    run_load(3, 5, -1, 1'b0, 12);
    chk("gap_chain", cur_chain(), 32'hA53CF);

    preload(32'h5A5A5);
    run_load(3, 0, 10, 1'b0, -1);
    run_load(3, 0, -1, 1'b0, 2);

    rand_words();
    preload($urandom);
    run_load(3, 1, int'($urandom_range(0, LA - 1)), 1'b1, -1);
    run_load(3, 0, -1, 1'b0, 7);

    for (int it = 0; it < 8; it++) begin
      rand_words();
      preload($urandom);
      if (it % 3 == 2)
        run_load(3, int'($urandom_range(0, 2)), int'($urandom_range(0, LA - 1)),
                 1'($urandom_range(0, 1)), -1);
      else
        run_load(3, int'($urandom_range(0, 3)), -1, 1'b0, int'($urandom_range(1, 15)));
    end

    sel = 1'b1;
    for (int it = 0; it < 3; it++) begin
      rand_words();
      preload($urandom);
      run_load(2, it, -1, 1'b0, int'($urandom_range(1, 10)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
